// File: rtl/linebuf_pkg.sv
// Shared types and helpers for the ping-pong scanline buffer.
package linebuf_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int PRIO_LAST  = 0;
  localparam int PRIO_FIRST = 1;

  // Callers zero-extend the pixel and mask to 32 bits.
  function automatic logic opaque(input logic [31:0] pix, input logic [31:0] mask);
    return (pix & mask) != 32'd0;
  endfunction

endpackage

// File: rtl/linebuf_bank.sv
// One scanline bank: port A reads and clears the location it reads,
// port B serves the compositing pipeline (separate read and write addresses).
module linebuf_bank
  import linebuf_pkg::*;
#(
  parameter int            AW   = 9,
  parameter int            DW   = 11,
  parameter logic [DW-1:0] CLRV = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_en,
  input  logic [AW-1:0] a_adr,
  output logic [DW-1:0] a_rdat,
  input  logic          b_re,
  input  logic [AW-1:0] b_radr,
  output logic [DW-1:0] b_rdat,
  input  logic          b_we,
  input  logic [AW-1:0] b_wadr,
  input  logic [DW-1:0] b_wdat
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] a_rdat_q;
  logic [DW-1:0] b_rdat_q;

  // Port B is written last so a pipeline write beats a clear to the same word.
  always_ff @(posedge clk) begin
    if (a_en) mem[a_adr] <= CLRV;
    if (b_we) mem[b_wadr] <= b_wdat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rdat_q <= '0;
      b_rdat_q <= '0;
    end else begin
      if (a_en) a_rdat_q <= mem[a_adr];
      if (b_re) b_rdat_q <= mem[b_radr];
    end
  end

  assign a_rdat = a_rdat_q;
  assign b_rdat = b_rdat_q;

endmodule

// File: rtl/linebuf_pp.sv
// Ping-pong scanline buffer: sprites composite into the write bank while
// scan-out reads and clears the other bank; priority, collision, init sweep.
module linebuf_pp
  import linebuf_pkg::*;
#(
  parameter int            AW        = 9,
  parameter int            DW        = 11,
  parameter logic [DW-1:0] TMASK     = 'h00F,
  parameter int            PRIO_MODE = PRIO_FIRST,
  parameter logic [DW-1:0] CLRV      = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          swap,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_adr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_adr,
  output logic [DW-1:0] rd_dat,
  output logic          rd_valid,
  output logic          coll,
  output logic          coll_line,
  output logic          busy,
  output logic          wbank
);

  state_e        state_q;
  logic [AW-1:0] init_cnt_q;
  logic          busy_q;
  logic          run, wr_go, rd_go, swap_go, init_we;

  logic          wbank_q, rd_valid_q, rd_bank_q, coll_q, sticky_q, coll_line_q;
  logic          s0_vld_q, s0_bank_q, s1_vld_q, s1_bank_q;
  logic          s2_we_q, s2_coll_q, s2_bank_q, wp_vld_q, wp_bank_q;
  logic [AW-1:0] s0_adr_q, s1_adr_q, s2_adr_q, wp_adr_q;
  logic [DW-1:0] s0_dat_q, s1_dat_q, s2_dat_q, wp_dat_q;
  logic [DW-1:0] exist_d;
  logic          new_opq, old_opq, s2_we_d, s2_coll_d;

  logic [1:0]    a_en, b_re, b_we;
  logic [DW-1:0] a_rdat [2];
  logic [DW-1:0] b_rdat [2];
  logic [AW-1:0] b_wadr;
  logic [DW-1:0] b_wdat;

  assign run     = (state_q == RUN);
  assign init_we = (state_q == INIT);
  assign wr_go   = wr_en && run;
  assign rd_go   = rd_en && run;
  assign swap_go = swap && run;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      busy_q     <= 1'b1;
    end else if (state_q == INIT) begin
      init_cnt_q <= init_cnt_q + AW'(1);
      if (init_cnt_q == '1) begin
        state_q <= RUN;
        busy_q  <= 1'b0;
      end
    end
  end

  assign b_wadr = init_we ? init_cnt_q : s2_adr_q;
  assign b_wdat = init_we ? CLRV : s2_dat_q;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      assign a_en[gi] = rd_go && (wbank_q != 1'(gi));
      assign b_re[gi] = s0_vld_q && (s0_bank_q == 1'(gi));
      assign b_we[gi] = init_we || (s2_we_q && (s2_bank_q == 1'(gi)));

      linebuf_bank #(.AW(AW), .DW(DW), .CLRV(CLRV)) u_bank (
        .clk    (clk),
        .reset  (reset),
        .a_en   (a_en[gi]),
        .a_adr  (rd_adr),
        .a_rdat (a_rdat[gi]),
        .b_re   (b_re[gi]),
        .b_radr (s0_adr_q),
        .b_rdat (b_rdat[gi]),
        .b_we   (b_we[gi]),
        .b_wadr (b_wadr),
        .b_wdat (b_wdat)
      );
    end
  endgenerate

  // The RAM read issued in S0 misses the write committed in that same cycle
  // (now held in wp_*), and cannot see the write happening during S1 at all.
  always_comb begin
    exist_d = s1_bank_q ? b_rdat[1] : b_rdat[0];
    if (wp_vld_q && (wp_adr_q == s1_adr_q) && (wp_bank_q == s1_bank_q)) exist_d = wp_dat_q;
    if (s2_we_q && (s2_adr_q == s1_adr_q) && (s2_bank_q == s1_bank_q)) exist_d = s2_dat_q;
    new_opq   = opaque(32'(s1_dat_q), 32'(TMASK));
    old_opq   = opaque(32'(exist_d), 32'(TMASK));
    s2_coll_d = s1_vld_q && new_opq && old_opq;
    s2_we_d   = s1_vld_q && new_opq && !((PRIO_MODE == PRIO_FIRST) && old_opq);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_vld_q    <= 1'b0;
      s1_vld_q    <= 1'b0;
      s2_we_q     <= 1'b0;
      s2_coll_q   <= 1'b0;
      wp_vld_q    <= 1'b0;
      wbank_q     <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_bank_q   <= 1'b0;
      coll_q      <= 1'b0;
      sticky_q    <= 1'b0;
      coll_line_q <= 1'b0;
    end else begin
      s0_vld_q   <= wr_go;
      s1_vld_q   <= s0_vld_q;
      s2_we_q    <= s2_we_d;
      s2_coll_q  <= s2_coll_d;
      wp_vld_q   <= s2_we_q;
      coll_q     <= s2_coll_q;
      rd_valid_q <= rd_go;
      if (rd_go) rd_bank_q <= ~wbank_q;
      if (swap_go) begin
        wbank_q     <= ~wbank_q;
        coll_line_q <= sticky_q | coll_q;
        sticky_q    <= 1'b0;
      end else begin
        sticky_q <= sticky_q | coll_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    s0_adr_q  <= wr_adr;
    s0_dat_q  <= wr_dat;
    s0_bank_q <= wbank_q;
    s1_adr_q  <= s0_adr_q;
    s1_dat_q  <= s0_dat_q;
    s1_bank_q <= s0_bank_q;
    s2_adr_q  <= s1_adr_q;
    s2_dat_q  <= s1_dat_q;
    s2_bank_q <= s1_bank_q;
    wp_adr_q  <= s2_adr_q;
    wp_dat_q  <= s2_dat_q;
    wp_bank_q <= s2_bank_q;
  end

  assign rd_dat    = rd_bank_q ? a_rdat[1] : a_rdat[0];
  assign rd_valid  = rd_valid_q;
  assign coll      = coll_q;
  assign coll_line = coll_line_q;
  assign busy      = busy_q;
  assign wbank     = wbank_q;

endmodule

// File: tb/tb_linebuf_pp.sv
// Bench for linebuf_pp: first-wins and last-wins instances share stimulus and
// are checked against a serialised array model of both banks.
module tb_linebuf_pp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        swap = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [8:0]  wr_adr = '0, rd_adr = '0;
  logic [10:0] wr_dat = '0;
  logic [10:0] rd_dat_f, rd_dat_l;
  logic        rd_valid_f, rd_valid_l, coll_f, coll_l;
  logic        coll_line_f, coll_line_l, busy_f, busy_l, wbank_f, wbank_l;

  int pass_cnt = 0, total_cnt = 0;

  // Reference model: writes commit at issue time, reads return and clear.
  logic [10:0] mf [2][512];
  logic [10:0] ml [2][512];
  bit          wb = 1'b0;
  bit          line_f = 1'b0, line_l = 1'b0, exp_line_f = 1'b0, exp_line_l = 1'b0;
  int          exp_coll_f = 0, exp_coll_l = 0, seen_f = 0, seen_l = 0;
  logic [10:0] exp_f, exp_l;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (coll_f) seen_f++;
    if (coll_l) seen_l++;
  end

  linebuf_pp #(.PRIO_MODE(1)) u_first (
    .clk(clk), .reset(reset), .swap(swap), .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat),
    .rd_en(rd_en), .rd_adr(rd_adr), .rd_dat(rd_dat_f), .rd_valid(rd_valid_f), .coll(coll_f),
    .coll_line(coll_line_f), .busy(busy_f), .wbank(wbank_f));

  linebuf_pp #(.PRIO_MODE(0)) u_last (
    .clk(clk), .reset(reset), .swap(swap), .wr_en(wr_en), .wr_adr(wr_adr), .wr_dat(wr_dat),
    .rd_en(rd_en), .rd_adr(rd_adr), .rd_dat(rd_dat_l), .rd_valid(rd_valid_l), .coll(coll_l),
    .coll_line(coll_line_l), .busy(busy_l), .wbank(wbank_l));

  function automatic bit opq(input logic [10:0] p);
    return (p & 11'h00F) != 11'h000;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 512; a++) begin
        mf[b][a] = '0;
        ml[b][a] = '0;
      end
    wb = 1'b0;
    line_f = 1'b0; line_l = 1'b0; exp_line_f = 1'b0; exp_line_l = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; swap = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic wr_set(input int adr, input logic [10:0] d);
    wr_en = 1'b1; wr_adr = 9'(adr); wr_dat = d;
    if (opq(d)) begin
      if (opq(mf[wb][adr])) begin exp_coll_f++; line_f = 1'b1; end
      else mf[wb][adr] = d;
      if (opq(ml[wb][adr])) begin exp_coll_l++; line_l = 1'b1; end
      ml[wb][adr] = d;
    end
  endtask

  task automatic rd_set(input int adr);
    int rb;
    rb = wb ? 0 : 1;
    rd_en = 1'b1; rd_adr = 9'(adr);
    exp_f = mf[rb][adr]; mf[rb][adr] = '0;
    exp_l = ml[rb][adr]; ml[rb][adr] = '0;
  endtask

  task automatic swap_set();
    swap = 1'b1;
    exp_line_f = line_f; exp_line_l = line_l;
    line_f = 1'b0; line_l = 1'b0;
    wb = ~wb;
  endtask

  task automatic wait_init(input int already);
    int bc;
    bc = already;
    while ((busy_f || busy_l) && bc < 600) begin
      if ($urandom_range(0, 1) == 1) begin
        wr_en = 1'b1; wr_adr = 9'($urandom_range(0, 511)); wr_dat = 11'($urandom);
      end
      rd_en = 1'($urandom_range(0, 1)); rd_adr = 9'($urandom_range(0, 511));
      swap = 1'($urandom_range(0, 1));
      step();
      if (busy_f || busy_l) bc++;
      total_cnt++;
      if (rd_valid_f || rd_valid_l || wbank_f || wbank_l)
        $display("FAIL init_ignore rd_valid=%b%b wbank=%b%b want 00 00", rd_valid_f, rd_valid_l, wbank_f, wbank_l);
      else pass_cnt++;
    end
    total_cnt++;
    if (bc !== 512 || busy_f !== busy_l) $display("FAIL busy_length got %0d cycles (busy %b/%b) want 512", bc, busy_f, busy_l);
    else pass_cnt++;
  endtask

  task automatic sweep_zero(input string tag);
    for (int a = 0; a < 512; a++) begin
      rd_set(a);
      step();
      total_cnt++;
      if ({rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l} !== {2'b11, exp_f, exp_l})
        $display("FAIL %s_sweep adr=%0d valid=%b%b dat=%h/%h want 11 %h/%h", tag, a, rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l, exp_f, exp_l);
      else pass_cnt++;
    end
    $display("%s: swept 512 locations of read bank %0d", tag, wb ? 0 : 1);
  endtask

  task automatic test_reset();
    model_reset();
    step();
    reset = 1'b0;
    total_cnt++;
    if ({busy_f, busy_l, rd_valid_f, rd_valid_l, coll_f, coll_l, coll_line_f, coll_line_l, wbank_f, wbank_l} !== 10'b11_00_00_00_00
        || rd_dat_f !== 11'h0 || rd_dat_l !== 11'h0)
      $display("FAIL reset_values busy=%b%b rv=%b%b coll=%b%b cl=%b%b wb=%b%b dat=%h/%h want busy=11 rest 0",
               busy_f, busy_l, rd_valid_f, rd_valid_l, coll_f, coll_l, coll_line_f, coll_line_l, wbank_f, wbank_l, rd_dat_f, rd_dat_l);
    else pass_cnt++;
    wait_init(1);
    sweep_zero("reset");
  endtask

  task automatic test_priority();
    int base_f, base_l;
    base_f = exp_coll_f; base_l = exp_coll_l;
    wr_set(100, 11'h015); step();
    wr_set(100, 11'h027); step();
    wr_set(100, 11'h010); step();
    drain();
    total_cnt++;
    if (seen_f !== exp_coll_f || seen_l !== exp_coll_l || exp_coll_f - base_f != 1 || exp_coll_l - base_l != 1)
      $display("FAIL prio_coll_count got %0d/%0d want %0d/%0d", seen_f, seen_l, exp_coll_f, exp_coll_l);
    else pass_cnt++;
    swap_set(); step();
    total_cnt++;
    if ({coll_line_f, coll_line_l, wbank_f, wbank_l} !== {exp_line_f, exp_line_l, wb, wb})
      $display("FAIL prio_coll_line got cl=%b%b wb=%b%b want %b%b %b%b", coll_line_f, coll_line_l, wbank_f, wbank_l, exp_line_f, exp_line_l, wb, wb);
    else pass_cnt++;
    rd_set(100); step();
    total_cnt++;
    if ({rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l} !== {2'b11, exp_f, exp_l} || exp_f !== 11'h015 || exp_l !== 11'h027)
      $display("FAIL prio_read got %b%b %h/%h want 11 015/027", rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l} !== {2'b00, exp_f, exp_l})
      $display("FAIL prio_hold got %b%b %h/%h want 00 %h/%h", rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l, exp_f, exp_l);
    else pass_cnt++;
    swap_set(); step();
    total_cnt++;
    if ({coll_line_f, coll_line_l} !== {exp_line_f, exp_line_l})
      $display("FAIL prio_line_clear got %b%b want %b%b", coll_line_f, coll_line_l, exp_line_f, exp_line_l);
    else pass_cnt++;
    swap_set(); step();
    rd_set(100); step();
    total_cnt++;
    if ({rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l} !== {2'b11, exp_f, exp_l} || exp_f !== 11'h0)
      $display("FAIL prio_reread got %b%b %h/%h want 11 %h/%h", rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l, exp_f, exp_l);
    else pass_cnt++;
    $display("priority: first-wins %h, last-wins read done", 11'h015);
  endtask

  task automatic test_back_to_back();
    int base_f;
    base_f = exp_coll_f;
    wr_set(7, 11'h031); step();
    wr_set(7, 11'h042); step();
    wr_set(7, 11'h053); step();
    drain();
    total_cnt++;
    if (seen_f !== exp_coll_f || seen_l !== exp_coll_l || exp_coll_f - base_f != 2)
      $display("FAIL b2b_coll_count got %0d/%0d want %0d/%0d", seen_f, seen_l, exp_coll_f, exp_coll_l);
    else pass_cnt++;
    swap_set(); step();
    rd_set(7); step();
    total_cnt++;
    if ({rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l} !== {2'b11, exp_f, exp_l} || exp_f !== 11'h031 || exp_l !== 11'h053)
      $display("FAIL b2b_read got %b%b %h/%h want 11 031/053", rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l);
    else pass_cnt++;
    $display("back_to_back: adr 7 composited 031/053");
  endtask

  task automatic test_swap_mid();
    wr_set(5, 11'h0A5); step();
    drain();
    swap_set(); step();
    wr_set(6, 11'h0C7); step();
    rd_set(5); wr_set(5, 11'h0B6); swap_set(); step();
    total_cnt++;
    if ({rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l} !== {2'b11, exp_f, exp_l} || exp_f !== 11'h0A5)
      $display("FAIL swapmid_old_read got %b%b %h/%h want 11 %h/%h", rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l, exp_f, exp_l);
    else pass_cnt++;
    total_cnt++;
    if ({wbank_f, wbank_l} !== {wb, wb}) $display("FAIL swapmid_wbank got %b%b want %b%b", wbank_f, wbank_l, wb, wb);
    else pass_cnt++;
    drain();
    for (int a = 5; a < 7; a++) begin
      rd_set(a); step();
      total_cnt++;
      if ({rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l} !== {2'b11, exp_f, exp_l} || !opq(exp_f))
        $display("FAIL swapmid_new_read adr=%0d got %b%b %h/%h want 11 %h/%h", a, rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l, exp_f, exp_l);
      else pass_cnt++;
    end
    $display("swap_mid: in-flight pixels landed in their tagged bank");
  endtask

  task automatic test_random();
    bit          did_rd;
    logic [10:0] d;
    for (int ln = 0; ln < 4; ln++) begin
      for (int c = 0; c < 48; c++) begin
        did_rd = 1'b0;
        if ($urandom_range(0, 3) != 0) begin
          d = 11'($urandom_range(0, 2047));
          if ($urandom_range(0, 3) == 0) d = d & 11'h7F0;
          wr_set($urandom_range(0, 15), d);
        end
        if ($urandom_range(0, 1) == 1) begin rd_set($urandom_range(0, 15)); did_rd = 1'b1; end
        step();
        if (did_rd) begin
          total_cnt++;
          if ({rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l} !== {2'b11, exp_f, exp_l})
            $display("FAIL rand_read line=%0d got %b%b %h/%h want 11 %h/%h", ln, rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l, exp_f, exp_l);
          else pass_cnt++;
        end
      end
      drain();
      total_cnt++;
      if (seen_f !== exp_coll_f || seen_l !== exp_coll_l)
        $display("FAIL rand_coll_count line=%0d got %0d/%0d want %0d/%0d", ln, seen_f, seen_l, exp_coll_f, exp_coll_l);
      else pass_cnt++;
      swap_set(); step();
      total_cnt++;
      if ({coll_line_f, coll_line_l, wbank_f, wbank_l} !== {exp_line_f, exp_line_l, wb, wb})
        $display("FAIL rand_swap line=%0d got cl=%b%b wb=%b%b want %b%b %b%b", ln, coll_line_f, coll_line_l, wbank_f, wbank_l, exp_line_f, exp_line_l, wb, wb);
      else pass_cnt++;
      $display("random: line %0d done, collisions %0d/%0d", ln, exp_coll_f, exp_coll_l);
    end
  endtask

  task automatic test_reset_mid();
    if (wb) begin swap_set(); step(); end
    wr_set(300, 11'h0FF); step();
    wr_set(300, 11'h0FF); step();
    drain();
    swap_set(); step();
    total_cnt++;
    if ({coll_line_f, coll_line_l, wbank_f, wbank_l} !== 4'b1111)
      $display("FAIL rmid_pre_state got cl=%b%b wb=%b%b want 11 11", coll_line_f, coll_line_l, wbank_f, wbank_l);
    else pass_cnt++;
    for (int i = 0; i < 20; i++) begin
      if (i < 10) wr_set(200 + i, 11'h101 | 11'(i));
      else begin wr_en = 1'b1; wr_adr = 9'(200 + i); wr_dat = 11'h1F1; end
      if (i == 5) rd_set(300);
      if (i == 10) begin reset = 1'b1; rd_en = 1'b1; rd_adr = 9'd300; end
      step();
      reset = 1'b0;
      if (i == 5) begin
        total_cnt++;
        if ({rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l} !== {2'b11, exp_f, exp_l} || exp_f !== 11'h0FF)
          $display("FAIL rmid_read got %b%b %h/%h want 11 %h/%h", rd_valid_f, rd_valid_l, rd_dat_f, rd_dat_l, exp_f, exp_l);
        else pass_cnt++;
      end
      if (i == 10) begin
        model_reset();
        total_cnt++;
        if ({busy_f, busy_l, rd_valid_f, rd_valid_l, coll_f, coll_l, coll_line_f, coll_line_l, wbank_f, wbank_l} !== 10'b11_00_00_00_00
            || rd_dat_f !== 11'h0 || rd_dat_l !== 11'h0)
          $display("FAIL rmid_reset_values busy=%b%b rv=%b%b coll=%b%b cl=%b%b wb=%b%b dat=%h/%h want busy=11 rest 0",
                   busy_f, busy_l, rd_valid_f, rd_valid_l, coll_f, coll_l, coll_line_f, coll_line_l, wbank_f, wbank_l, rd_dat_f, rd_dat_l);
        else pass_cnt++;
      end
    end
    wait_init(10);
    sweep_zero("reset_mid_b1");
    swap_set(); step();
    total_cnt++;
    if ({coll_line_f, coll_line_l, wbank_f, wbank_l} !== 4'b0011)
      $display("FAIL rmid_swap got cl=%b%b wb=%b%b want 00 11", coll_line_f, coll_line_l, wbank_f, wbank_l);
    else pass_cnt++;
    sweep_zero("reset_mid_b0");
    total_cnt++;
    if (seen_f !== exp_coll_f || seen_l !== exp_coll_l)
      $display("FAIL rmid_coll_count got %0d/%0d want %0d/%0d", seen_f, seen_l, exp_coll_f, exp_coll_l);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_priority();
    test_back_to_back();
    test_swap_mid();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
